// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags, written by ROB commit and read by the decoder.
// Optional same-cycle commit-to-read forwarding is enabled by defining REGFILE_COMMIT_BYPASS_EN.
module reg_file_rename #(
    parameter int REG_NUM   = 32,
    parameter int DATA_W    = 32,
    parameter int ROB_TAG_W = 4,
    localparam int IDX_W    = $clog2(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,

    input  logic [IDX_W-1:0]     in_decoder_reg1,
    output logic [DATA_W-1:0]    out_decoder_value1,
    output logic [ROB_TAG_W-1:0] out_decoder_tag1,
    input  logic [IDX_W-1:0]     in_decoder_reg2,
    output logic [DATA_W-1:0]    out_decoder_value2,
    output logic [ROB_TAG_W-1:0] out_decoder_tag2,

    input  logic                 in_fetcher_flag,
    input  logic [IDX_W-1:0]     in_decoder_rd,
    input  logic [ROB_TAG_W-1:0] in_decoder_rd_tag,

    input  logic [IDX_W-1:0]     in_rob_commit_index,
    input  logic [ROB_TAG_W-1:0] in_rob_commit_tag,
    input  logic [DATA_W-1:0]    in_rob_commit_value,
    input  logic                 in_rob_xbp,

    output logic [31:0]          out_commit_count
);

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    value;
    } read_t;

    logic [DATA_W-1:0]    value_q [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_q   [REG_NUM];

    logic  commit_active;
    logic  rename_active;
    logic  commit_clears_tag;
    read_t rd_port1;
    read_t rd_port2;

    // A rename squashed by a flush must not touch the tag table at all.
    assign commit_active = rdy && (in_rob_commit_index != '0);
    assign rename_active = rdy && in_fetcher_flag && (in_decoder_rd != '0) && !in_rob_xbp;

    // The commit only releases the tag if it is still the youngest producer and
    // no new producer is being renamed onto the same register this cycle.
    assign commit_clears_tag = commit_active
                            && (tag_q[in_rob_commit_index] == in_rob_commit_tag)
                            && !(rename_active && (in_decoder_rd == in_rob_commit_index));

    function automatic read_t read_port(input logic [IDX_W-1:0] r);
        read_t res;
        res.value = '0;
        res.tag   = '0;
        if (r != '0) begin
            res.value = value_q[r];
            res.tag   = tag_q[r];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (commit_active && (r == in_rob_commit_index) && (tag_q[r] == in_rob_commit_tag)) begin
                res.value = in_rob_commit_value;
                res.tag   = '0;
            end
`endif
        end
        return res;
    endfunction

    assign rd_port1 = read_port(in_decoder_reg1);
    assign rd_port2 = read_port(in_decoder_reg2);

    assign out_decoder_value1 = rd_port1.value;
    assign out_decoder_tag1   = rd_port1.tag;
    assign out_decoder_value2 = rd_port2.value;
    assign out_decoder_tag2   = rd_port2.tag;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the pre-edge value regardless of statement order.
    // NOTE: the value array is reset here because reset must return every
    // architectural register to zero, not just the tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            out_commit_count <= '0;
        end else if (rdy) begin
            if (commit_active) begin
                value_q[in_rob_commit_index] <= in_rob_commit_value;
                out_commit_count             <= out_commit_count + 32'd1;
            end
            if (in_rob_xbp) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                if (commit_clears_tag) begin
                    tag_q[in_rob_commit_index] <= '0;
                end
                if (rename_active) begin
                    tag_q[in_decoder_rd] <= in_decoder_rd_tag;
                end
            end
        end
    end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file plus rename-tag table, sitting directly downstream of the ROB commit port and read by the decoder at issue.
- Holds 32 x 32-bit registers and, per register, the ROB tag of the youngest in-flight producer.
- Decoder gets either a committed value (tag 0) or a ROB tag to wait on.
- Commit writes value and releases the tag only if the tag still matches; a misprediction flush clears all tags.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hardwired to zero)
DATA_W, 32, register data width
ROB_TAG_W, 4, ROB tag width; tag 0 means "no producer / value valid"

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset, sampled on posedge clk
rdy  input  1  global enable; when low, all state holds
in_decoder_reg1  input  5  source register 1 index
out_decoder_value1  output  32  register 1 value (valid when out_decoder_tag1==0)
out_decoder_tag1  output  4  producer ROB tag for reg1, 0 = ready
in_decoder_reg2  input  5  source register 2 index
out_decoder_value2  output  32  register 2 value
out_decoder_tag2  output  4  producer ROB tag for reg2, 0 = ready
in_fetcher_flag  input  1  issue strobe: the decoder entry is being allocated this cycle
in_decoder_rd  input  5  destination register of issuing instr, 0 = none
in_decoder_rd_tag  input  4  ROB tag allocated to issuing instr
in_rob_commit_index  input  5  committing destination register, 0 = no commit
in_rob_commit_tag  input  4  ROB tag of committing entry
in_rob_commit_value  input  32  committed value
in_rob_xbp  input  1  misbranch flush from ROB
out_commit_count  output  32  number of non-x0 register commits since reset

Behaviour:
- Reset (rst=1 at posedge): all values=0, all tags=0, out_commit_count=0. rst has priority over rdy.
- rdy=0: no state change; read outputs remain combinational on current state.
- Reads are combinational. Reg 0 always returns value 0, tag 0.
- Otherwise, return value[r] and tag[r]; the bypass rule is under Optional Feature.
- Commit (rdy=1, in_rob_commit_index!=0):
  - value[idx] <= in_rob_commit_value.
  - out_commit_count increments by 1, wrapping at 2^32.
  - tag[idx] <= 0 only if tag[idx]==in_rob_commit_tag; otherwise tag is untouched (a younger producer owns it).
- Rename (rdy=1, in_fetcher_flag=1, in_decoder_rd!=0, in_rob_xbp=0): tag[rd] <= in_decoder_rd_tag.
- Commit and rename to the same register in the same cycle: the value is written, the new rename tag wins, and the commit's tag-clear is suppressed.
- Flush (rdy=1, in_rob_xbp=1):
  - All 32 tags <= 0 next cycle.
  - A commit presented the same cycle (e.g. JALR link) still writes its value and counts.
  - A rename presented the same cycle is discarded.
- Writes to x0 are ignored entirely and do not count.
- Latency: a commit or rename is visible to registered-state reads the cycle after the posedge.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: if a read index is non-zero, equals in_rob_commit_index, and the register's tag equals in_rob_commit_tag while a commit is active (and rdy=1), the read returns in_rob_commit_value with tag 0 in the same cycle.
- Not defined: reads reflect registered state only; the decoder resolves that case via the ROB fetch ports.

Test Plan:
- Reset, then read x5 and x0 -> value 0, tag 0 on both ports; out_commit_count=0.
- Issue rd=5 tag=3 -> next cycle reg1=5 returns tag 3. Commit idx=5 tag=3 value=0xDEADBEEF -> next cycle tag 0, value 0xDEADBEEF, count=1.
- Rename x7 to tag 2, then tag 6. Commit x7 tag 2 value 0x11 -> value 0x11 written, tag stays 6.
- Same cycle: commit x9 tag 4 value 0x55 and rename x9 tag 8 -> next cycle value 0x55, tag 8.
- Tags on x1..x3 = 1,2,3. Assert in_rob_xbp with commit x1 tag 1 value 0x1000 and rename x4 tag 5 -> all tags 0, x1=0x1000, x4 tag 0, count+1.
- Bypass with macro defined: x10 tag 9, read x10 during commit tag 9 value 0x42 -> same-cycle value 0x42, tag 0. Without the macro -> tag 9 that cycle, value 0x42 the next cycle.
